// File: rtl/core_seq_pkg.sv
// core_seq_pkg: shared definitions for the core instruction sequencer.
//   - seq_state_t   : sequencer state encoding
//   - B_* / A*_HI/LO: bit positions inside the 39-bit instruction word
//   - IDLE_INST     : quiescent word (SRAM enables/writes deasserted)
//   - active_word() : idle word carrying the latched simd/op_mode config bits
package core_seq_pkg;

  localparam int SEQ_ROW     = 8;
  localparam int SEQ_COL     = 8;
  localparam int SEQ_INST_BW = 39;
  localparam int SEQ_ADDR_W  = 11;
  localparam int SEQ_CNT_W   = 11;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    WLOAD = 4'd1,
    WPUSH = 4'd2,
    XLOAD = 4'd3,
    EXEC  = 4'd4,
    DRAIN = 4'd5,
    ORD   = 4'd6,
    SFU   = 4'd7,
    DONE  = 4'd8
  } seq_state_t;

  // Instruction word bit positions
  localparam int B_SIMD      = 38;
  localparam int B_SFU_RELU  = 37;
  localparam int B_SFU_ACC   = 36;
  localparam int B_LD_MODE   = 35;
  localparam int B_OP_MODE   = 34;
  localparam int B_ACC       = 33;
  localparam int B_CEN_PMEM  = 32;
  localparam int B_WEN_PMEM  = 31;
  localparam int AP_HI       = 30;
  localparam int AP_LO       = 20;
  localparam int B_CEN_XMEM  = 19;
  localparam int B_WEN_XMEM  = 18;
  localparam int AX_HI       = 17;
  localparam int AX_LO       = 7;
  localparam int B_OFIFO_RD  = 6;
  localparam int B_IFIFO_WR  = 5;
  localparam int B_IFIFO_RD  = 4;
  localparam int B_L0_RD     = 3;
  localparam int B_L0_WR     = 2;
  localparam int B_EXECUTE   = 1;
  localparam int B_LOAD      = 0;

  // CEN/WEN of both SRAMs high (active-low, so deasserted), everything else 0.
  localparam logic [SEQ_INST_BW-1:0] IDLE_INST = 39'h01_800C_0000;

  // Idle word decorated with the tile-wide config bits.
  function automatic logic [SEQ_INST_BW-1:0] active_word(input logic simd,
                                                         input logic op);
    logic [SEQ_INST_BW-1:0] w;
    w            = IDLE_INST;
    w[B_SIMD]    = simd;
    w[B_OP_MODE] = op;
    return w;
  endfunction

endpackage

// File: rtl/core_seq_rdgen.sv
// core_seq_rdgen: SRAM read-address generator shared by the weight and
// activation load phases.
//   clk, reset : clock, async active-low reset
//   en         : high for the whole load phase; low clears the counter
//   base, len  : first address and number of reads of this phase
//   rd         : issue a read this cycle (CEN low)
//   addr       : read address, base + index, wrapping modulo 2^ADDR_W
//   l0_wr      : read strobe delayed one cycle (SRAM read latency is 1)
//   last       : final cycle of the phase (index == len, only l0_wr active)
module core_seq_rdgen
  import core_seq_pkg::*;
#(
  parameter int ADDR_W = SEQ_ADDR_W,
  parameter int CNT_W  = SEQ_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [ADDR_W-1:0] base,
  input  logic [CNT_W-1:0]  len,
  output logic              rd,
  output logic [ADDR_W-1:0] addr,
  output logic              l0_wr,
  output logic              last
);

  logic [CNT_W-1:0] idx;
  logic             rd_d;

  assign rd    = en && (idx < len);
  assign last  = en && (idx == len);
  assign addr  = base + ADDR_W'(idx);
  assign l0_wr = rd_d;

  // Index counter plus read strobe delayed to line up with SRAM data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx  <= '0;
      rd_d <= 1'b0;
    end else if (!en) begin
      idx  <= '0;
      rd_d <= 1'b0;
    end else begin
      idx  <= idx + CNT_W'(1);
      rd_d <= rd;
    end
  end

endmodule

// File: rtl/core_seq.sv
// core_seq: instruction sequencer directly upstream of the core.
// Turns one start pulse plus a tile descriptor into the per-cycle
// instruction stream: per kernel position (kij) weight fetch, weight push,
// activation fetch, execute, then OFIFO drain into psum SRAM.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   start               one-cycle pulse, only honoured in IDLE
//   w_base/x_base/p_base xmem weight / xmem activation / pmem psum bases
//   n_act, n_kij        activations per kij, number of kernel positions
//   cfg_simd, cfg_op    copied into inst[38] / inst[34] while active
//   cfg_relu            (only with CORE_SEQ_SFU_PASS_EN) sfu_relu in SFU
//   ofifo_valid         core OFIFO holds a full output set
//   inst                registered instruction word
//   busy, done          tile in progress / one-cycle end-of-tile pulse
//
// Optional feature macro: CORE_SEQ_SFU_PASS_EN adds an SFU pass over the
// psums after the last kij and the cfg_relu port.
//
// Outputs are registered from the current-state word, so each state's
// first word appears one cycle after the state is entered.
module core_seq
  import core_seq_pkg::*;
#(
  parameter int row     = SEQ_ROW,
  parameter int col     = SEQ_COL,
  parameter int inst_bw = SEQ_INST_BW,
  parameter int ADDR_W  = SEQ_ADDR_W,
  parameter int CNT_W   = SEQ_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  w_base,
  input  logic [ADDR_W-1:0]  x_base,
  input  logic [ADDR_W-1:0]  p_base,
  input  logic [CNT_W-1:0]   n_act,
  input  logic [CNT_W-1:0]   n_kij,
  input  logic               cfg_simd,
  input  logic               cfg_op,
`ifdef CORE_SEQ_SFU_PASS_EN
  input  logic               cfg_relu,
`endif
  input  logic               ofifo_valid,
  output logic [inst_bw-1:0] inst,
  output logic               busy,
  output logic               done
);

  seq_state_t         state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   kij;
  logic [CNT_W-1:0]   n_act_r;
  logic [CNT_W-1:0]   n_kij_r;
  logic [ADDR_W-1:0]  w_cur;      // w_base + kij*row, kept as a running sum
  logic [ADDR_W-1:0]  x_base_r;
  logic [ADDR_W-1:0]  p_base_r;
  logic               simd_r;
  logic               op_r;
`ifdef CORE_SEQ_SFU_PASS_EN
  logic               relu_r;
`endif

  logic               rg_en;
  logic [ADDR_W-1:0]  rg_base;
  logic [CNT_W-1:0]   rg_len;
  logic               rg_rd;
  logic [ADDR_W-1:0]  rg_addr;
  logic               rg_l0_wr;
  logic               rg_last;

  logic [inst_bw-1:0] word;
  logic               cnt_last;
  logic               push_last;
  logic               kij_more;

  assign cnt_last  = (cnt == (n_act_r - CNT_W'(1)));
  assign push_last = (cnt == CNT_W'(row + col - 1));
  assign kij_more  = ((kij + CNT_W'(1)) < n_kij_r);

  // Select read-generator setup for the weight or activation load phase.
  always_comb begin
    rg_en   = 1'b0;
    rg_base = x_base_r;
    rg_len  = n_act_r;
    if (state == WLOAD) begin
      rg_en   = 1'b1;
      rg_base = w_cur;
      rg_len  = CNT_W'(row);
    end else if (state == XLOAD) begin
      rg_en   = 1'b1;
    end else begin
      rg_en   = 1'b0;
    end
  end

  core_seq_rdgen #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_rdgen (
    .clk   (clk),
    .reset (reset),
    .en    (rg_en),
    .base  (rg_base),
    .len   (rg_len),
    .rd    (rg_rd),
    .addr  (rg_addr),
    .l0_wr (rg_l0_wr),
    .last  (rg_last)
  );

  // Instruction word for the current state and counters.
  always_comb begin
    word = IDLE_INST;
    case (state)
      WLOAD, XLOAD: begin
        word            = active_word(simd_r, op_r);
        word[B_LD_MODE] = (state == WLOAD);
        if (rg_rd) begin
          word[B_CEN_XMEM]  = 1'b0;
          word[AX_HI:AX_LO] = rg_addr;
        end else begin
          word[B_CEN_XMEM]  = 1'b1;
        end
        word[B_L0_WR]   = rg_l0_wr;
      end
      WPUSH: begin
        word            = active_word(simd_r, op_r);
        word[B_LD_MODE] = 1'b1;
        // first row cycles push weights; the col tail lets them propagate
        if (cnt < CNT_W'(row)) begin
          word[B_L0_RD] = 1'b1;
          word[B_LOAD]  = 1'b1;
        end else begin
          word[B_L0_RD] = 1'b0;
          word[B_LOAD]  = 1'b0;
        end
      end
      EXEC: begin
        word            = active_word(simd_r, op_r);
        word[B_L0_RD]   = 1'b1;
        word[B_EXECUTE] = 1'b1;
      end
      DRAIN: begin
        word = active_word(simd_r, op_r);
      end
      ORD: begin
        word              = active_word(simd_r, op_r);
        word[B_OFIFO_RD]  = 1'b1;
        word[B_CEN_PMEM]  = 1'b0;
        word[B_WEN_PMEM]  = 1'b0;
        word[AP_HI:AP_LO] = p_base_r + ADDR_W'(cnt);
        // first kij overwrites psums, later kijs accumulate
        word[B_ACC]       = (kij != '0);
      end
      SFU: begin
`ifdef CORE_SEQ_SFU_PASS_EN
        word              = active_word(simd_r, op_r);
        word[B_CEN_PMEM]  = 1'b0;
        word[AP_HI:AP_LO] = p_base_r + ADDR_W'(cnt);
        word[B_SFU_ACC]   = 1'b1;
        word[B_SFU_RELU]  = relu_r;
`else
        word = IDLE_INST;
`endif
      end
      IDLE, DONE: begin
        word = IDLE_INST;
      end
      default: begin
        word = IDLE_INST;
      end
    endcase
  end

  // Sequencer FSM with config latch and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      kij      <= '0;
      n_act_r  <= '0;
      n_kij_r  <= '0;
      w_cur    <= '0;
      x_base_r <= '0;
      p_base_r <= '0;
      simd_r   <= 1'b0;
      op_r     <= 1'b0;
`ifdef CORE_SEQ_SFU_PASS_EN
      relu_r   <= 1'b0;
`endif
      inst     <= IDLE_INST;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      inst <= word;
      busy <= (state != IDLE) && (state != DONE);
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            n_act_r  <= n_act;
            n_kij_r  <= n_kij;
            w_cur    <= w_base;
            x_base_r <= x_base;
            p_base_r <= p_base;
            simd_r   <= cfg_simd;
            op_r     <= cfg_op;
`ifdef CORE_SEQ_SFU_PASS_EN
            relu_r   <= cfg_relu;
`endif
            cnt      <= '0;
            kij      <= '0;
            // empty tile: skip straight to DONE without touching SRAM
            if ((n_act == '0) || (n_kij == '0)) begin
              state <= DONE;
            end else begin
              state <= WLOAD;
            end
          end
        end
        WLOAD: begin
          if (rg_last) begin
            state <= WPUSH;
            cnt   <= '0;
          end
        end
        WPUSH: begin
          if (push_last) begin
            state <= XLOAD;
            cnt   <= '0;
          end else begin
            cnt   <= cnt + CNT_W'(1);
          end
        end
        XLOAD: begin
          if (rg_last) begin
            state <= EXEC;
            cnt   <= '0;
          end
        end
        EXEC: begin
          if (cnt_last) begin
            state <= DRAIN;
            cnt   <= '0;
          end else begin
            cnt   <= cnt + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (ofifo_valid) begin
            state <= ORD;
            cnt   <= '0;
          end
        end
        ORD: begin
          if (cnt_last) begin
            cnt <= '0;
            if (kij_more) begin
              kij   <= kij + CNT_W'(1);
              w_cur <= w_cur + ADDR_W'(row);
              state <= WLOAD;
            end else begin
`ifdef CORE_SEQ_SFU_PASS_EN
              state <= SFU;
`else
              state <= DONE;
`endif
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SFU: begin
`ifdef CORE_SEQ_SFU_PASS_EN
          if (cnt_last) begin
            state <= DONE;
            cnt   <= '0;
          end else begin
            cnt   <= cnt + CNT_W'(1);
          end
`else
          state <= IDLE;
`endif
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_seq.sv
`timescale 1ns/1ps
module tb_core_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [10:0] w_base;
  logic [10:0] x_base;
  logic [10:0] p_base;
  logic [10:0] n_act;
  logic [10:0] n_kij;
  logic        cfg_simd;
  logic        cfg_op;
`ifdef CORE_SEQ_SFU_PASS_EN
  logic        cfg_relu;
`endif
  logic        ofifo_valid;
  logic [38:0] inst;
  logic        busy;
  logic        done;

  int          compared;
  int          mismatched;
  int          done_cnt;
  logic [38:0] sb[$];
  int          cd;
  logic        prev_ex;

  core_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .w_base      (w_base),
    .x_base      (x_base),
    .p_base      (p_base),
    .n_act       (n_act),
    .n_kij       (n_kij),
    .cfg_simd    (cfg_simd),
    .cfg_op      (cfg_op),
`ifdef CORE_SEQ_SFU_PASS_EN
    .cfg_relu    (cfg_relu),
`endif
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .busy        (busy),
    .done        (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [38:0] idle_w();
    logic [38:0] w;
    w     = '0;
    w[32] = 1'b1;
    w[31] = 1'b1;
    w[19] = 1'b1;
    w[18] = 1'b1;
    return w;
  endfunction

  function automatic logic [38:0] base_w(input logic simd, input logic op);
    logic [38:0] w;
    w     = idle_w();
    w[38] = simd;
    w[34] = op;
    return w;
  endfunction

  function automatic logic is_active(input logic [38:0] w);
    return (!w[19]) || (!w[32]) || (|w[6:0]) || w[37] || w[36];
  endfunction

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected active words of a whole tile, built from the instruction layout.
  task automatic push_tile(input logic [10:0] wb, input logic [10:0] xb, input logic [10:0] pb,
                           input int na, input int nk, input logic simd, input logic op);
    logic [38:0] w;
    logic [10:0] wofs;
    wofs = wb;
    for (int k = 0; k < nk; k++) begin
      for (int i = 0; i <= 8; i++) begin
        w = base_w(simd, op);
        w[35] = 1'b1;
        if (i < 8) begin w[19] = 1'b0; w[17:7] = wofs + 11'(i); end
        if (i >= 1) w[2] = 1'b1;
        sb.push_back(w);
      end
      for (int i = 0; i < 8; i++) begin
        w = base_w(simd, op);
        w[35] = 1'b1; w[3] = 1'b1; w[0] = 1'b1;
        sb.push_back(w);
      end
      for (int j = 0; j <= na; j++) begin
        w = base_w(simd, op);
        if (j < na) begin w[19] = 1'b0; w[17:7] = xb + 11'(j); end
        if (j >= 1) w[2] = 1'b1;
        sb.push_back(w);
      end
      for (int j = 0; j < na; j++) begin
        w = base_w(simd, op);
        w[3] = 1'b1; w[1] = 1'b1;
        sb.push_back(w);
      end
      for (int j = 0; j < na; j++) begin
        w = base_w(simd, op);
        w[6] = 1'b1; w[32] = 1'b0; w[31] = 1'b0;
        w[30:20] = pb + 11'(j);
        w[33] = (k != 0);
        sb.push_back(w);
      end
      wofs = wofs + 11'd8;
    end
`ifdef CORE_SEQ_SFU_PASS_EN
    for (int j = 0; j < na; j++) begin
      w = base_w(simd, op);
      w[32] = 1'b0; w[30:20] = pb + 11'(j);
      w[36] = 1'b1; w[37] = 1'b1;
      sb.push_back(w);
    end
`endif
  endtask

  // Monitor: every active word is popped from the scoreboard and compared.
  initial begin
    done_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (done === 1'b1) begin
          done_cnt++;
          check("busy_at_done", {39'd0, busy}, 40'd0);
        end
        if (is_active(inst)) begin
          if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_word: got %h expected none", inst);
          end else begin
            check("inst_word", {busy, inst}, {1'b1, sb.pop_front()});
          end
        end
      end
    end
  end

  // Core model: raise ofifo_valid 5 cycles after execute ends, drop on first read.
  initial begin
    cd = 0;
    prev_ex = 1'b0;
    ofifo_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (cd > 0) begin
        cd--;
        if (cd == 0) ofifo_valid = 1'b1;
      end
      if (prev_ex && !inst[1]) cd = 5;
      if (inst[6]) ofifo_valid = 1'b0;
      prev_ex = inst[1];
    end
  end

  task automatic set_desc(input logic [10:0] wb, input logic [10:0] xb, input logic [10:0] pb,
                          input logic [10:0] na, input logic [10:0] nk,
                          input logic simd, input logic op);
    w_base = wb; x_base = xb; p_base = pb; n_act = na; n_kij = nk;
    cfg_simd = simd; cfg_op = op;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string name);
    int t;
    t = 0;
    while ((done_cnt == d0) && (t < 3000)) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt == d0) begin
      compared++;
      mismatched++;
      $display("FAIL %s_timeout: got no done expected done", name);
    end
  endtask

  task automatic wait_bit(input int b, input string name);
    int t;
    t = 0;
    while ((inst[b] !== 1'b1) && (t < 3000)) begin
      @(negedge clk);
      t++;
    end
    if (inst[b] !== 1'b1) begin
      compared++;
      mismatched++;
      $display("FAIL %s_timeout: got no bit %0d expected bit set", name, b);
    end
  endtask

  task automatic finish_check(input int d0, input string name);
    repeat (5) @(negedge clk);
    check({name, "_leftover"}, 40'(sb.size()), 40'd0);
    check({name, "_done_count"}, 40'(done_cnt - d0), 40'd1);
  endtask

  task automatic run_tile(input logic [10:0] wb, input logic [10:0] xb, input logic [10:0] pb,
                          input int na, input int nk, input logic simd, input logic op,
                          input string name);
    int d0;
    d0 = done_cnt;
    set_desc(wb, xb, pb, 11'(na), 11'(nk), simd, op);
    push_tile(wb, xb, pb, na, nk, simd, op);
    pulse_start();
    wait_done(d0, name);
    finish_check(d0, name);
  endtask

  initial begin
    int d0;
    compared = 0;
    mismatched = 0;
    reset = 1'b0;
    start = 1'b0;
    set_desc(11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 1'b0, 1'b0);
`ifdef CORE_SEQ_SFU_PASS_EN
    cfg_relu = 1'b1;
`endif
    repeat (3) @(negedge clk);
    check("rst_inst", {1'b0, inst}, {1'b0, idle_w()});
    check("rst_busy", {39'd0, busy}, 40'd0);
    check("rst_done", {39'd0, done}, 40'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // single tile
    run_tile(11'd0, 11'd64, 11'd128, 4, 1, 1'b0, 1'b0, "tile1");

    // three kernel positions, config bits set
    run_tile(11'd0, 11'd64, 11'd128, 2, 3, 1'b1, 1'b1, "kij3");

    // empty tile: done two cycles after start, no SRAM activity
    d0 = done_cnt;
    set_desc(11'd0, 11'd64, 11'd128, 11'd0, 11'd1, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("nact0_done", {39'd0, done}, 40'd1);
    check("nact0_inst", {1'b0, inst}, {1'b0, idle_w()});
    finish_check(d0, "nact0");

    // start during EXEC with a different descriptor is ignored
    d0 = done_cnt;
    set_desc(11'd0, 11'd64, 11'd128, 11'd4, 11'd1, 1'b0, 1'b0);
    push_tile(11'd0, 11'd64, 11'd128, 4, 1, 1'b0, 1'b0);
    pulse_start();
    wait_bit(1, "exec");
    start = 1'b1;
    n_act = 11'd7;
    w_base = 11'd500;
    @(negedge clk);
    start = 1'b0;
    n_act = 11'd4;
    w_base = 11'd0;
    wait_done(d0, "restart");
    finish_check(d0, "restart");

    // asynchronous reset in the middle of ORD
    set_desc(11'd0, 11'd64, 11'd128, 11'd4, 11'd1, 1'b0, 1'b0);
    push_tile(11'd0, 11'd64, 11'd128, 4, 1, 1'b0, 1'b0);
    pulse_start();
    wait_bit(6, "ord");
    #2;
    reset = 1'b0;
    #1;
    check("midrst_inst", {1'b0, inst}, {1'b0, idle_w()});
    check("midrst_busy", {39'd0, busy}, 40'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    run_tile(11'd0, 11'd64, 11'd128, 4, 1, 1'b0, 1'b0, "after_rst");

    // weight address wrap at the top of xmem
    run_tile(11'd2044, 11'd100, 11'd200, 1, 1, 1'b0, 1'b0, "wrap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
